// File: rtl/mips32_mem_bus.sv
// Multi-cycle MIPS32 data-memory interconnect: decodes one CPU load/store to a bank,
// steers byte lanes, waits on the bank ack and records faults in a sticky register.
module mips32_mem_bus #(
  parameter int          NUM_BANKS      = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h10010000,
  parameter int          BANK_ADDR_BITS = 13,
  parameter int          TIMEOUT        = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [1:0]                  cpu_size,
  input  logic                        cpu_sext,
  input  logic [31:0]                 cpu_wdata,
  output logic                        cpu_ack,
  output logic [31:0]                 cpu_rdata,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic [3:0]                  bank_we,
  output logic [BANK_ADDR_BITS-3:0]   bank_addr,
  output logic [31:0]                 bank_wdata,
  input  logic [32*NUM_BANKS-1:0]     bank_rdata,
  input  logic [NUM_BANKS-1:0]        bank_ack,
  output logic                        fault_valid,
  output logic [1:0]                  fault_cause,
  output logic [31:0]                 fault_addr,
  input  logic                        fault_clr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(NUM_BANKS) << BANK_ADDR_BITS);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        req_we, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] rdata_q;

  logic                 bad_align, unmapped, timeout_hit;
  logic [29:0]          off_w, idx;
  logic [NUM_BANKS-1:0] sel;
  logic [31:0]          sel_rdata;
  logic                 sel_ack;

  function automatic logic [31:0] load_steer(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return sext ? {{24{b[7]}}, b} : {24'h0, b};
      2'd1:    return sext ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Address checks and bank decode on the incoming request
  always_comb begin
    bad_align = (cpu_size == 2'd3) || (cpu_size == 2'd1 && cpu_addr[0]) ||
                (cpu_size == 2'd2 && cpu_addr[1:0] != 2'd0);
    unmapped  = (cpu_addr < BASE_ADDR) || ({1'b0, cpu_addr} >= END_ADDR);
    off_w     = cpu_addr[31:2] - BASE_ADDR[31:2];
    idx       = off_w >> (BANK_ADDR_BITS - 2);
    sel       = '0;
    for (int i = 0; i < NUM_BANKS; i++) sel[i] = (idx == 30'(i));
  end

  // Only the bank currently enabled may complete the access
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_en[i]) begin
        sel_rdata = sel_rdata | bank_rdata[32*i +: 32];
        sel_ack   = sel_ack | bank_ack[i];
      end
    end
  end

  assign timeout_hit = (cnt + 8'd1 == 8'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = (bad_align || unmapped) ? FAULT : ACCESS;
      ACCESS:  if (sel_ack) state_nxt = RESP;
               else if (timeout_hit) state_nxt = FAULT;
      RESP:    state_nxt = IDLE;
      FAULT:   if (fault_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      bank_en     <= '0;
      bank_we     <= '0;
      bank_addr   <= '0;
      bank_wdata  <= '0;
      fault_valid <= 1'b0;
      fault_cause <= '0;
      fault_addr  <= '0;
      cnt         <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      case (state)
        IDLE: if (cpu_req) begin
          if (bad_align || unmapped) begin
            fault_valid <= 1'b1;
            fault_cause <= bad_align ? 2'd2 : 2'd1;
            fault_addr  <= cpu_addr;
          end else begin
            bank_en    <= sel;
            bank_addr  <= off_w[BANK_ADDR_BITS-3:0];
            bank_we    <= cpu_we ? store_mask(cpu_size, cpu_addr[1:0]) : 4'b0000;
            bank_wdata <= store_data(cpu_size, cpu_wdata);
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (sel_ack || timeout_hit) begin
            bank_en <= '0;
            bank_we <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
          if (!sel_ack && timeout_hit) begin
            fault_valid <= 1'b1;
            fault_cause <= 2'd3;
            fault_addr  <= req_addr;
          end
        end
        RESP: begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= rdata_q;
        end
        FAULT: if (fault_clr) begin
          fault_valid <= 1'b0;
          fault_cause <= '0;
          fault_addr  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Request attributes and the steered load result
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      req_we   <= cpu_we;
      req_size <= cpu_size;
      req_sext <= cpu_sext;
      req_addr <= cpu_addr;
    end
    if (state == ACCESS && sel_ack)
      rdata_q <= req_we ? 32'h0 : load_steer(sel_rdata, req_addr[1:0], req_size, req_sext);
  end

endmodule

// File: tb/tb_mips32_mem_bus.sv
// Directed bench for mips32_mem_bus with a small zero-wait memory model per bank.
module tb_mips32_mem_bus;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_sext, cpu_ack, fault_clr, fault_valid;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, bank_wdata, fault_addr;
  logic [1:0]        cpu_size, fault_cause;
  logic [NB-1:0]     bank_en, bank_ack, ack_en;
  logic [3:0]        bank_we;
  logic [10:0]       bank_addr;
  logic [32*NB-1:0]  bank_rdata;
  logic [31:0]       mem [NB][16] = '{default: '0};

  int errors = 0;
  int checks = 0;

  mips32_mem_bus dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_size(cpu_size), .cpu_sext(cpu_sext), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .bank_ack(bank_ack),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  assign bank_ack = bank_en & ack_en;
  for (genvar g = 0; g < NB; g++) begin : g_rd
    assign bank_rdata[32*g +: 32] = mem[g][bank_addr[3:0]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (bank_en[i] && bank_ack[i])
        for (int b = 0; b < 4; b++)
          if (bank_we[b]) mem[i][bank_addr[3:0]][8*b +: 8] <= bank_wdata[8*b +: 8];
  end

  // Issue one request and wait for its ack; snapshot the bank side after the sampling edge.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sext, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat,
                           output logic [NB-1:0] en0, output logic [3:0] we0,
                           output logic [10:0] ad0, output logic [31:0] wd0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
    cpu_sext = sext; cpu_wdata = wdata;
    lat = -1; rdata = 32'hx; en0 = '0; we0 = '0; ad0 = '0; wd0 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin en0 = bank_en; we0 = bank_we; ad0 = bank_addr; wd0 = bank_wdata; end
      if (cpu_ack) begin lat = c; rdata = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic clear_fault();
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_size = 0; cpu_sext = 0;
    cpu_wdata = 0; fault_clr = 0; ack_en = '1;
    #1;
    checks++;
    if ({cpu_ack, cpu_rdata, bank_en, bank_we, bank_addr, bank_wdata, fault_valid, fault_cause, fault_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs: ack=%b en=%b we=%h fv=%b required all zero", cpu_ack, bank_en, bank_we, fault_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_byte_load();
    logic [31:0] rd, wd; int lat; logic [NB-1:0] en; logic [3:0] we; logic [10:0] ad;
    do_access(1, 32'h10010004, 2'd2, 0, 32'hDEADBEEF, rd, lat, en, we, ad, wd);
    checks++; if (en !== 4'b0001) begin errors++; $display("FAIL sw_bank_en: got %b want 0001", en); end
    checks++; if (ad !== 11'd1) begin errors++; $display("FAIL sw_bank_addr: got %0d want 1", ad); end
    checks++; if (we !== 4'hF) begin errors++; $display("FAIL sw_bank_we: got %h want f", we); end
    checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", wd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rd); end
    do_access(0, 32'h10010007, 2'd0, 1, 0, rd, lat, en, we, ad, wd);
    checks++; if (we !== 4'h0) begin errors++; $display("FAIL lb_we: got %h want 0", we); end
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_sext: got %h want ffffffde", rd); end
    do_access(0, 32'h10010004, 2'd0, 0, 0, rd, lat, en, we, ad, wd);
    checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu: got %h want 000000ef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd, wd; int lat; logic [NB-1:0] en; logic [3:0] we; logic [10:0] ad;
    do_access(1, 32'h10012002, 2'd1, 0, 32'h00001234, rd, lat, en, we, ad, wd);
    checks++; if (en !== 4'b0010) begin errors++; $display("FAIL sh_bank_en: got %b want 0010", en); end
    checks++; if (we !== 4'b1100) begin errors++; $display("FAIL sh_bank_we: got %b want 1100", we); end
    checks++; if (wd !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", wd); end
    do_access(0, 32'h10012002, 2'd1, 0, 0, rd, lat, en, we, ad, wd);
    checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu: got %h want 00001234", rd); end
  endtask

  task automatic test_misalign();
    int acks = 0, ens = 0; logic seen = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010002; cpu_size = 2'd2; cpu_sext = 0;
    repeat (2) begin @(posedge clk); #1; acks += cpu_ack; ens += (bank_en != 0); end
    checks++; if (fault_valid !== 1'b1 || fault_cause !== 2'd2) begin errors++; $display("FAIL misalign_cause: got v=%b c=%0d want v=1 c=2", fault_valid, fault_cause); end
    checks++; if (fault_addr !== 32'h10010002) begin errors++; $display("FAIL misalign_addr: got %h want 10010002", fault_addr); end
    @(negedge clk); cpu_addr = 32'h10010004; cpu_size = 2'd2;
    repeat (5) begin @(posedge clk); #1; acks += cpu_ack; ens += (bank_en != 0); end
    checks++; if (acks !== 0 || ens !== 0) begin errors++; $display("FAIL fault_stall: acks=%0d en_cycles=%0d want 0 and 0", acks, ens); end
    checks++; if (fault_valid !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", fault_valid); end
    @(negedge clk); fault_clr = 1;
    @(posedge clk); #1; fault_clr = 0;
    checks++; if ({fault_valid, fault_cause, fault_addr} !== '0) begin errors++; $display("FAIL fault_clr: v=%b c=%0d a=%h want all 0", fault_valid, fault_cause, fault_addr); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin seen = 1; break; end
    end
    checks++; if (seen !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL after_clr_accept: ack=%b rdata=%h want 1 deadbeef", seen, cpu_rdata); end
    cpu_req = 0;
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = 32'h10018000; addrs[1] = 32'h0FFFFFFC;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = addrs[k]; cpu_size = 2'd2;
      @(posedge clk); #1;
      checks++; if (fault_valid !== 1'b1 || fault_cause !== 2'd1 || fault_addr !== addrs[k] || bank_en !== '0) begin
        errors++; $display("FAIL unmapped_%0d: v=%b c=%0d a=%h en=%b want 1 1 %h 0", k, fault_valid, fault_cause, fault_addr, bank_en, addrs[k]);
      end
      cpu_req = 0;
      clear_fault();
    end
  endtask

  task automatic test_timeout();
    int en_cycles = 0; logic hit = 0;
    ack_en[2] = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10014000; cpu_size = 2'd2;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bank_en[2]) en_cycles++;
      if (fault_valid) begin hit = 1; break; end
    end
    cpu_req = 0;
    checks++; if (en_cycles !== 15) begin errors++; $display("FAIL timeout_en_cycles: got %0d want 15", en_cycles); end
    checks++; if (hit !== 1'b1 || fault_cause !== 2'd3 || fault_addr !== 32'h10014000 || bank_en !== '0) begin
      errors++; $display("FAIL timeout_fault: v=%b c=%0d a=%h en=%b want 1 3 10014000 0", hit, fault_cause, fault_addr, bank_en);
    end
    clear_fault();
    ack_en[2] = 1;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd, wd; int lat; logic [NB-1:0] en; logic [3:0] we; logic [10:0] ad;
    ack_en[2] = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10014000; cpu_size = 2'd2;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (bank_en !== 4'b0100) begin errors++; $display("FAIL mid_access_en: got %b want 0100", bank_en); end
    rst = 0; #1;
    checks++; if ({cpu_ack, cpu_rdata, bank_en, bank_we, bank_addr, bank_wdata, fault_valid, fault_cause, fault_addr} !== '0) begin
      errors++; $display("FAIL mid_access_reset: en=%b addr=%0d fv=%b required all zero", bank_en, bank_addr, fault_valid);
    end
    @(negedge clk); rst = 1; cpu_req = 0; ack_en[2] = 1;
    do_access(0, 32'h10012002, 2'd1, 1, 0, rd, lat, en, we, ad, wd);
    checks++; if (lat !== 3 || rd !== 32'h00001234) begin errors++; $display("FAIL post_reset_access: lat=%0d rdata=%h want 3 00001234", lat, rd); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1; logic [31:0] r1 = 0, r2 = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010004; cpu_size = 2'd2; cpu_sext = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        if (t1 < 0) begin
          t1 = c; r1 = cpu_rdata;
          cpu_addr = 32'h10010006; cpu_size = 2'd1; cpu_sext = 1;
        end else begin
          t2 = c; r2 = cpu_rdata; break;
        end
      end
    end
    cpu_req = 0;
    checks++; if (t1 < 0 || t2 - t1 !== 3) begin errors++; $display("FAIL b2b_spacing: t1=%0d t2=%0d want 3 apart", t1, t2); end
    checks++; if (r1 !== 32'hDEADBEEF || r2 !== 32'hFFFFDEAD) begin errors++; $display("FAIL b2b_data: got %h %h want deadbeef ffffdead", r1, r2); end
    @(posedge clk); #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b want 0", cpu_ack); end
  endtask

  initial begin
    test_reset();
    test_word_store_byte_load();
    test_half();
    test_misalign();
    test_unmapped();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
